// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped dynamic branch predictor (BHT + BTB).
//
// The IF stage presents pc_i and gets a same-cycle hit/taken/target
// prediction read straight from the table registers. The EX stage trains
// the table with resolved conditional branches through the upd_* port.
// Each entry holds a valid bit, a tag, a 2-bit saturating counter and a
// 30-bit word-aligned target.
//
// Optional feature macro: BP_BYPASS_EN
//   defined   - a lookup to the index being updated in the same cycle sees
//               the post-update entry (next-state forwarding).
//   undefined - lookups always see the registered (pre-update) entry.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  output logic        pred_hit_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Counter encodings: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------

  // Table index: word-address bits just above the byte offset.
  function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
    pc_idx = pc[IDX_W+1:2];
  endfunction

  // Tag: the TAG_W bits directly above the index.
  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    pc_tag = pc[IDX_W+TAG_W+1:IDX_W+2];
  endfunction

  // Saturating increment towards strong-taken.
  function automatic logic [1:0] cnt_inc(input logic [1:0] cnt);
    case (cnt)
      CNT_SNT: cnt_inc = CNT_WNT;
      CNT_WNT: cnt_inc = CNT_WT;
      CNT_WT:  cnt_inc = CNT_ST;
      CNT_ST:  cnt_inc = CNT_ST;
      default: cnt_inc = CNT_WNT;
    endcase
  endfunction

  // Saturating decrement towards strong-not-taken.
  function automatic logic [1:0] cnt_dec(input logic [1:0] cnt);
    case (cnt)
      CNT_SNT: cnt_dec = CNT_SNT;
      CNT_WNT: cnt_dec = CNT_SNT;
      CNT_WT:  cnt_dec = CNT_WNT;
      CNT_ST:  cnt_dec = CNT_WT;
      default: cnt_dec = CNT_WNT;
    endcase
  endfunction

  // Predict taken for the two upper counter states.
  function automatic logic cnt_taken(input logic [1:0] cnt);
    cnt_taken = cnt[1];
  endfunction

  // ---------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------
  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [1:0]        cnt_r    [ENTRIES];
  logic [29:0]       target_r [ENTRIES];

  // ---------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]  upd_idx_s;
  logic [TAG_W-1:0]  upd_tag_s;
  logic              upd_fire_s;
  logic              upd_hit_s;
  logic              upd_we_s;
  logic              nxt_valid_s;
  logic [TAG_W-1:0]  nxt_tag_s;
  logic [1:0]        nxt_cnt_s;
  logic [29:0]       nxt_target_s;

  // A reset cycle swallows any concurrent update, so it never fires then.
  assign upd_idx_s  = pc_idx(upd_pc_i);
  assign upd_tag_s  = pc_tag(upd_pc_i);
  assign upd_fire_s = upd_valid_i & ~stall_i & rst_n;
  assign upd_hit_s  = valid_r[upd_idx_s] & (tag_r[upd_idx_s] == upd_tag_s);

  // Next-state of the indexed entry for the resolved branch in EX.
  always_comb begin
    upd_we_s     = 1'b0;
    nxt_valid_s  = valid_r[upd_idx_s];
    nxt_tag_s    = tag_r[upd_idx_s];
    nxt_cnt_s    = cnt_r[upd_idx_s];
    nxt_target_s = target_r[upd_idx_s];
    if (upd_fire_s) begin
      if (upd_hit_s) begin
        upd_we_s = 1'b1;
        if (upd_taken_i) begin
          nxt_cnt_s    = cnt_inc(cnt_r[upd_idx_s]);
          nxt_target_s = upd_target_i[31:2];
        end else begin
          nxt_cnt_s    = cnt_dec(cnt_r[upd_idx_s]);
        end
      end else if (upd_taken_i) begin
        // Allocate, evicting whatever aliased into this slot.
        upd_we_s     = 1'b1;
        nxt_valid_s  = 1'b1;
        nxt_tag_s    = upd_tag_s;
        nxt_cnt_s    = CNT_WT;
        nxt_target_s = upd_target_i[31:2];
      end else begin
        // A not-taken branch we do not track teaches us nothing.
        upd_we_s     = 1'b0;
      end
    end else begin
      upd_we_s = 1'b0;
    end
  end

  // Table registers: reset wipes all history, else write the indexed entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        cnt_r[i]    <= CNT_WNT;
        target_r[i] <= 30'd0;
      end
    end else if (upd_we_s) begin
      valid_r[upd_idx_s]  <= nxt_valid_s;
      tag_r[upd_idx_s]    <= nxt_tag_s;
      cnt_r[upd_idx_s]    <= nxt_cnt_s;
      target_r[upd_idx_s] <= nxt_target_s;
    end
  end

  // ---------------------------------------------------------------------
  // Lookup path
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]  lk_idx_s;
  logic [TAG_W-1:0]  lk_tag_s;
  logic              rd_valid_s;
  logic [TAG_W-1:0]  rd_tag_s;
  logic [1:0]        rd_cnt_s;
  logic [29:0]       rd_target_s;
  logic              lk_hit_s;

  assign lk_idx_s = pc_idx(pc_i);
  assign lk_tag_s = pc_tag(pc_i);

  // Select the entry seen by the fetch PC (optionally forwarded).
  always_comb begin
    rd_valid_s  = valid_r[lk_idx_s];
    rd_tag_s    = tag_r[lk_idx_s];
    rd_cnt_s    = cnt_r[lk_idx_s];
    rd_target_s = target_r[lk_idx_s];
`ifdef BP_BYPASS_EN
    if (upd_we_s && (upd_idx_s == lk_idx_s)) begin
      rd_valid_s  = nxt_valid_s;
      rd_tag_s    = nxt_tag_s;
      rd_cnt_s    = nxt_cnt_s;
      rd_target_s = nxt_target_s;
    end else begin
      rd_valid_s  = valid_r[lk_idx_s];
      rd_tag_s    = tag_r[lk_idx_s];
      rd_cnt_s    = cnt_r[lk_idx_s];
      rd_target_s = target_r[lk_idx_s];
    end
`endif
  end

  assign lk_hit_s      = rd_valid_s & (rd_tag_s == lk_tag_s);
  assign pred_hit_o    = lk_hit_s;
  assign pred_taken_o  = lk_hit_s & cnt_taken(rd_cnt_s);
  assign pred_target_o = lk_hit_s ? {rd_target_s, 2'b00} : 32'd0;

  // Byte-offset and high PC bits play no part in indexing or tagging.
  logic unused_s;
  assign unused_s = ^{pc_i, upd_pc_i, upd_target_i[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed bench for branch_predictor (ENTRIES=64,
// TAG_W=8). A per-index table model predicts every lookup each cycle;
// literal expectations pin the model along the directed sequence.
module tb_branch_predictor;

  localparam int ENT  = 64;
  localparam int TAGN = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic [31:0] pc_i;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;

  int tests = 0;
  int fails = 0;

  branch_predictor #(.ENTRIES(64), .TAG_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .pc_i         (pc_i),
    .pred_hit_o   (pred_hit_o),
    .pred_taken_o (pred_taken_o),
    .pred_target_o(pred_target_o),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_taken_i  (upd_taken_i),
    .upd_target_i (upd_target_i)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------------
  // Model: per-slot valid / tag / counter (0..3) / target
  // ------------------------------------------------------------------
  bit          m_valid [ENT];
  int          m_tag   [ENT];
  int          m_cnt   [ENT];
  logic [31:0] m_tgt   [ENT];
  bit          model_ready = 1'b0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(ENT));
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc / 32'(4 * ENT)) % 32'(TAGN));
  endfunction

  // Apply one resolved branch to a single entry.
  function automatic void train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                                inout bit v, inout int tg, inout int c, inout logic [31:0] t);
    if (v && tg == tag_of(pc)) begin
      if (tk) begin
        c = (c == 3) ? 3 : c + 1;
        t = tgt & 32'hFFFF_FFFC;
      end else begin
        c = (c == 0) ? 0 : c - 1;
      end
    end else if (tk) begin
      v  = 1'b1;
      tg = tag_of(pc);
      c  = 2;
      t  = tgt & 32'hFFFF_FFFC;
    end
  endfunction

  function automatic bit fires();
    return upd_valid_i && !stall_i && rst_n;
  endfunction

  // Model state advance on the active edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENT; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = 0; m_cnt[i] = 1; m_tgt[i] = 32'd0;
      end
      model_ready = 1'b1;
    end else if (model_ready && fires()) begin
      int i; bit v; int tg; int c; logic [31:0] t;
      i = idx_of(upd_pc_i);
      v = m_valid[i]; tg = m_tag[i]; c = m_cnt[i]; t = m_tgt[i];
      train(upd_pc_i, upd_taken_i, upd_target_i, v, tg, c, t);
      m_valid[i] = v; m_tag[i] = tg; m_cnt[i] = c; m_tgt[i] = t;
    end
  end

  // Every-cycle compare of the lookup outputs against the model.
  always @(negedge clk) begin
    if (model_ready) begin
      int i; bit v; int tg; int c; logic [31:0] t;
      bit eh; bit et; logic [31:0] etg;
      i = idx_of(pc_i);
      v = m_valid[i]; tg = m_tag[i]; c = m_cnt[i]; t = m_tgt[i];
`ifdef BP_BYPASS_EN
      if (fires() && idx_of(upd_pc_i) == i)
        train(upd_pc_i, upd_taken_i, upd_target_i, v, tg, c, t);
`endif
      eh  = v && (tg == tag_of(pc_i));
      et  = eh && (c >= 2);
      etg = eh ? t : 32'd0;
      tests++;
      if (pred_hit_o !== eh || pred_taken_o !== et || pred_target_o !== etg) begin
        fails++;
        $display("FAIL model_cmp t=%0t pc=%h got hit=%b tk=%b tgt=%h expected hit=%b tk=%b tgt=%h",
                 $time, pc_i, pred_hit_o, pred_taken_o, pred_target_o, eh, et, etg);
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic go();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    upd_valid_i = 1'b1; upd_pc_i = pc; upd_taken_i = tk; upd_target_i = tgt;
    go();
    upd_valid_i = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input bit eh,
                      input bit et, input logic [31:0] etg);
    pc_i = pc;
    mid();
    chk({name, "_hit"},   {31'd0, pred_hit_o},   {31'd0, eh});
    chk({name, "_taken"}, {31'd0, pred_taken_o}, {31'd0, et});
    chk({name, "_tgt"},   pred_target_o, etg);
    go();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    go();
    rst_n = 1'b1;
  endtask

  // ------------------------------------------------------------------
  // Directed sequence
  // ------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; stall_i = 1'b0; pc_i = 32'd0;
    upd_valid_i = 1'b0; upd_pc_i = 32'd0; upd_taken_i = 1'b0; upd_target_i = 32'd0;
    go(); go();
    rst_n = 1'b1;

    // Reset sweep: nothing hits anywhere.
    for (int a = 0; a <= 32'h1FC; a += 4) begin
      pc_i = 32'(a);
      mid();
      chk("reset_sweep_hit", {31'd0, pred_hit_o}, 32'd0);
      chk("reset_sweep_taken", {31'd0, pred_taken_o}, 32'd0);
      chk("reset_sweep_tgt", pred_target_o, 32'd0);
      go();
    end

    // Allocate and predict.
    pc_i = 32'h0;
    upd(32'h100, 1'b1, 32'h80);
    look("alloc",     32'h100, 1'b1, 1'b1, 32'h80);
    look("alloc_nbr", 32'h104, 1'b0, 1'b0, 32'h0);

    // Saturation and hysteresis (counter 10 after allocation).
    pc_i = 32'h0;
    upd(32'h100, 1'b1, 32'h80); look("sat_t1",  32'h100, 1'b1, 1'b1, 32'h80);
    pc_i = 32'h0;
    upd(32'h100, 1'b1, 32'h80); look("sat_t2",  32'h100, 1'b1, 1'b1, 32'h80);
    pc_i = 32'h0;
    upd(32'h100, 1'b0, 32'h0);  look("hys_nt1", 32'h100, 1'b1, 1'b1, 32'h80);
    pc_i = 32'h0;
    upd(32'h100, 1'b0, 32'h0);  look("hys_nt2", 32'h100, 1'b1, 1'b0, 32'h80);
    pc_i = 32'h0;
    upd(32'h100, 1'b0, 32'h0);  look("hys_nt3", 32'h100, 1'b1, 1'b0, 32'h80);
    pc_i = 32'h0;
    upd(32'h100, 1'b0, 32'h0);  look("hys_nt4", 32'h100, 1'b1, 1'b0, 32'h80);
    pc_i = 32'h0;
    upd(32'h100, 1'b1, 32'h84); look("floor_t", 32'h100, 1'b1, 1'b0, 32'h84);

    // Aliasing: 0x200 shares index 0 with 0x100 but has a different tag.
    pc_i = 32'h0;
    upd(32'h200, 1'b1, 32'h300);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h0);
    look("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);
    upd(32'h300, 1'b0, 32'h500);
    look("nt_miss_keep", 32'h200, 1'b1, 1'b1, 32'h300);
    look("nt_miss_none", 32'h300, 1'b0, 1'b0, 32'h0);
    upd(32'h200, 1'b1, 32'h402);
    look("tgt_change", 32'h200, 1'b1, 1'b1, 32'h400);

    // Stall gating: three stalled cycles then one live cycle.
    pc_i = 32'h40;
    upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b1; upd_target_i = 32'h1000;
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("stall_no_lookup_effect", {31'd0, pred_hit_o}, 32'd0);
      go();
    end
    stall_i = 1'b0;
    go();
    upd_valid_i = 1'b0;
    look("stall_alloc", 32'h40, 1'b1, 1'b1, 32'h1000);
    upd(32'h40, 1'b0, 32'h0);
    look("stall_once", 32'h40, 1'b1, 1'b0, 32'h1000);

    // Reset mid-training, with an update in the reset cycle that must drop.
    upd_valid_i = 1'b1; upd_pc_i = 32'h100; upd_taken_i = 1'b1; upd_target_i = 32'h80;
    rst_n = 1'b0;
    go();
    rst_n = 1'b1; upd_valid_i = 1'b0;
    look("rst_drop",   32'h100, 1'b0, 1'b0, 32'h0);
    look("rst_clear",  32'h40,  1'b0, 1'b0, 32'h0);

    // Same-cycle conflict on index of 0x100.
    pc_i = 32'h100;
    upd_valid_i = 1'b1; upd_pc_i = 32'h100; upd_taken_i = 1'b1; upd_target_i = 32'h80;
    mid();
`ifdef BP_BYPASS_EN
    chk("conflict_same_hit", {31'd0, pred_hit_o}, 32'd1);
    chk("conflict_same_tgt", pred_target_o, 32'h80);
`else
    chk("conflict_same_hit", {31'd0, pred_hit_o}, 32'd0);
    chk("conflict_same_tgt", pred_target_o, 32'h0);
`endif
    go();
    upd_valid_i = 1'b0;
    look("conflict_next", 32'h100, 1'b1, 1'b1, 32'h80);

    do_reset();
    go();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor (BHT plus BTB) for the pipelined RISC-V core. It replaces static predict-not-taken, where a taken branch resolved in EX costs a flush. The IF stage presents the fetch PC and receives a same-cycle taken/target prediction. The EX stage writes back the resolved outcome, which trains a direct-mapped table of 2-bit saturating counters with tags and targets.

## Interface
Parameters:
- ENTRIES, 64, number of table entries; power of 2, range 4..1024; IDX_W = log2(ENTRIES)
- TAG_W, 8, tag bits stored per entry; IDX_W+TAG_W+2 <= 32

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous, active-low
- stall_i  in  1  pipeline memory stall (ICACHE_stall | DCACHE_stall); blocks updates
- pc_i  in  32  IF-stage fetch PC (byte address)
- pred_hit_o  out  1  lookup entry valid and tag matches
- pred_taken_o  out  1  predict taken
- pred_target_o  out  32  predicted target; 0 when pred_hit_o=0
- upd_valid_i  in  1  EX holds a resolved conditional branch
- upd_pc_i  in  32  PC of the resolved branch
- upd_taken_i  in  1  actual outcome
- upd_target_i  in  32  actual taken target (PC+imm)

## Operation
- Address split: idx = pc[IDX_W+1:2], tag = pc[IDX_W+TAG_W+1:IDX_W+2]. The same split applies to upd_pc_i.
- Per-entry state: valid (1 bit), tag (TAG_W), cnt (2 bits), target (30 bits, word address; low 2 bits are implicit 0).
- Lookup (combinational from table registers):
  - pred_hit_o = valid[idx] & (tag[idx]==tag(pc_i))
  - pred_taken_o = pred_hit_o & cnt[idx][1]
  - pred_target_o = pred_hit_o ? {target[idx],2'b00} : 0
- Update fires when upd_valid_i & ~stall_i. It fires exactly once per resolved branch, because EX is frozen while stalled.
  - Hit (valid and tag match):
    - taken: cnt saturating increment (11 stays 11); target <= upd_target_i[31:2]
    - not taken: cnt saturating decrement (00 stays 00); target unchanged
  - Miss, taken: allocate; valid <= 1, tag <= upd tag, cnt <= 2'b10, target <= upd_target_i[31:2]. Overwrites any aliasing entry.
  - Miss, not taken: no state change.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff cnt >= 10.
- Only the indexed entry changes per cycle; every other entry holds.

## Timing
- Lookup latency 0 cycles (pure combinational from registers).
- An update is visible to lookups from the cycle after the update edge.
- Simultaneous lookup and update to the same idx: behaviour is set by BP_BYPASS_EN (see Configuration).
- Reset (rst_n=0 at an edge) clears all valid bits and sets all cnt to 01; tag and target may also be cleared.
- After reset, pred_hit_o=0, pred_taken_o=0 and pred_target_o=0 for every pc_i.
- Reset asserted mid-training discards all history; an update in the same cycle as reset is dropped.
- stall_i has no effect on lookup outputs.

## Configuration
- BP_BYPASS_EN defined:
  - When an update fires and its idx equals the lookup idx, the lookup outputs reflect the post-update entry in the same cycle (next-state forwarding).
  - This covers allocation, counter change and target change.
  - Adds one comparator and a mux on the lookup path.
- BP_BYPASS_EN undefined: lookup always reads the registered (pre-update) entry; no forwarding.

## Test plan
- Reset then lookup: pulse rst_n low one cycle; sweep pc_i over 0x0..0x1FC -> pred_hit_o=0, pred_taken_o=0, pred_target_o=0 everywhere.
- Allocate and predict: update pc 0x100, taken, target 0x80 -> next cycle, lookup pc_i=0x100 gives hit=1, taken=1, target=0x80; pc_i=0x104 gives hit=0.
- Saturation and hysteresis: from allocation (10) apply T,T -> cnt 11; then NT -> still predict taken; NT again -> predict not-taken (01); two more NT -> 00 and stays 00.
- Aliasing (ENTRIES=64, TAG_W=8): allocate 0x100, then a taken update at 0x200 (same idx, different tag) -> 0x100 now misses; 0x200 hits with its new target. A not-taken miss at 0x300 changes nothing.
- Stall gating: hold upd_valid_i=1 (pc 0x40, taken) for 3 cycles with stall_i=1, then 1 cycle with stall_i=0 -> entry is allocated exactly once, cnt=10 (not 11).
- Same-cycle conflict: pc_i=upd_pc_i=0x100 with a taken allocate -> hit=1 in that cycle with BP_BYPASS_EN defined; hit=0 without it. Both builds show hit=1 on the following cycle.
